// File: rtl/sa_host_pkg.sv
// Shared types and constants for the systolic-array host sequencer.
package sa_host_pkg;

  localparam int SA_N     = 8;
  localparam int SA_DEPTH = 16;
  localparam int SA_KW    = 5;

  // Bit positions of the engine controls within its uio_in byte.
  localparam int CTRL_READOUT = 0;
  localparam int CTRL_USEXOR  = 1;
  localparam int CTRL_SAYHI   = 7;

  typedef enum logic [2:0] {
    IDLE,
    FEED_A,
    FEED_B,
    READ,
    DONE
  } seq_state_e;

endpackage

// File: rtl/sa_operand_ram.sv
// Operand pair buffer: one synchronous write port, one asynchronous read port.
module sa_operand_ram #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_a,
  input  logic [N-1:0]  wr_b,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_a,
  output logic [N-1:0]  rd_b
);

  logic [2*N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {wr_a, wr_b};
  end

  assign rd_a = mem_q[rd_addr][2*N-1:N];
  assign rd_b = mem_q[rd_addr][N-1:0];

endmodule

// File: rtl/sa_host_sequencer.sv
// Host-side initiator for the boolean outer-product engine: streams operand
// pairs, runs the readout and captures the result rows.
//
// state  | meaning
// IDLE   | readout held high, engine phase aligned and flushed; waits for start
// FEED_A | present A[k] on the engine byte input
// FEED_B | present B[k]; advance k, go to READ after the last step
// READ   | N readout cycles, capturing one result row per cycle
// DONE   | one-cycle done pulse, back to IDLE
module sa_host_sequencer
  import sa_host_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int DEPTH = SA_DEPTH,
  parameter int KW    = SA_KW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [N-1:0]             ld_a,
  input  logic [N-1:0]             ld_b,
  input  logic [KW-1:0]            k_len,
  input  logic                     xor_mode,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [$clog2(N)-1:0]     res_addr,
  output logic [N-1:0]             res_data,
  output logic [7:0]               dut_ui,
  output logic                     dut_readout,
  output logic                     dut_usexor,
  output logic                     dut_sayhi,
  input  logic [7:0]               dut_uo
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(N);

  seq_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] kk_q, kk_d;
  logic [RW-1:0] r_q, r_d;
  logic          xor_q, xor_d;
  logic [7:0]    ui_q, ui_d;
  logic          readout_q, readout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  res_q [N];

  logic [KW-1:0] kk_sat;
  logic [N-1:0]  rd_a, rd_b;
  logic [RW-1:0] res_idx;

  assign kk_sat = (k_len > KW'(DEPTH)) ? KW'(DEPTH) : k_len;

  sa_operand_ram #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (ld_en & ~busy_q),
    .wr_addr (ld_addr),
    .wr_a    (ld_a),
    .wr_b    (ld_b),
    .rd_addr (k_d[AW-1:0]),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    kk_d    = kk_q;
    r_d     = r_q;
    xor_d   = xor_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          kk_d    = kk_sat;
          xor_d   = xor_mode;
          k_d     = '0;
          r_d     = '0;
          state_d = (kk_sat == '0) ? READ : FEED_A;
        end
      end
      FEED_A: state_d = FEED_B;
      FEED_B: begin
        k_d     = k_q + KW'(1);
        state_d = (k_d == kk_q) ? READ : FEED_A;
      end
      READ: begin
        if (r_q == RW'(N - 1)) state_d = DONE;
        else                   r_d = r_q + RW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Engine-facing outputs are computed from the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    ui_d      = '0;
    readout_d = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_d)
      FEED_A: begin
        ui_d      = 8'(rd_a);
        readout_d = 1'b0;
        busy_d    = 1'b1;
      end
      FEED_B: begin
        ui_d      = 8'(rd_b);
        readout_d = 1'b0;
        busy_d    = 1'b1;
      end
      READ:    busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      kk_q      <= '0;
      r_q       <= '0;
      xor_q     <= 1'b0;
      ui_q      <= '0;
      readout_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      kk_q      <= kk_d;
      r_q       <= r_d;
      xor_q     <= xor_d;
      ui_q      <= ui_d;
      readout_q <= readout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Readout cycle r carries row N-1-r, so rows fill from the top down.
  assign res_idx = RW'(N - 1) - r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else if (state_q == READ) begin
      res_q[res_idx] <= dut_uo[N-1:0];
    end
  end

  assign res_data    = res_q[res_addr];
  assign busy        = busy_q;
  assign done        = done_q;
  assign dut_ui      = ui_q;
  assign dut_readout = readout_q;
  assign dut_usexor  = xor_q;
  assign dut_sayhi   = 1'b0;

endmodule
